// File: rtl/fifo_async_pkg.sv
// Shared definitions for the asynchronous FIFO pointer controllers.
// This file holds the default geometry and the Gray/binary conversion helpers.
// The write-side and read-side controllers both use these helpers.
package fifo_async_pkg;

  // Default geometry: 16-entry FIFO, almost_full at 12 entries.
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_AFULL_TH   = 12;

  // The conversion helpers work on a word wide enough for any pointer.
  // Each caller zero-extends its pointer into this word and truncates the result.
  // Zero upper bits stay zero through both conversions, so the narrow
  // result is exact for any pointer up to GRAY_MAX_W bits.
  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Binary to reflected Gray code.
  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code to binary. Each bit is the XOR of all Gray bits at or above it.
  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
// Only one bit of a Gray pointer changes per step. After the second flop the
// value is therefore either the old pointer or the new one, never a mix.
module fifo_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_async,
  output logic [WIDTH-1:0] q_sync
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // Next-state for the two synchronizer stages: a plain shift.
  always_comb begin
    meta_d = d_async;
    sync_d = meta_q;
  end

  // Synchronizer flops. A synchronous reset clears both stages.
  // NOTE: state flops use non-blocking assignments. Every flop then samples
  // pre-edge values, and the two stages stay a true two-cycle delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_sync = sync_q;

endmodule

// File: rtl/fifo_async_wr_ctrl.sv
// Write-domain pointer controller for an asynchronous FIFO.
// It drives the RAM write port and keeps the binary and Gray write pointers.
// It synchronizes the read pointer from the read domain and derives the
// full, almost_full, occupancy and sticky overflow status.
// The status is pessimistic: a read becomes visible two edges late, so the
// controller can never overrun the RAM.
// ADDR_WIDTH must be at least 2.
module fifo_async_wr_ctrl
  import fifo_async_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AFULL_TH   = FIFO_AFULL_TH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  output logic                  wr_accept,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  input  logic [ADDR_WIDTH:0]   rptr_gray_async,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  // Pointers carry one extra wrap bit, which tells a full FIFO from an empty one.
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AFULL_TH_P = PTR_W'(AFULL_TH);

  // Registered state.
  logic [PTR_W-1:0] wbin_d,        wbin_q;
  logic [PTR_W-1:0] wptr_gray_d,   wptr_gray_q;
  logic             full_d,        full_q;
  logic             almost_full_d, almost_full_q;
  logic [PTR_W-1:0] wr_count_d,    wr_count_q;
  logic             overflow_d,    overflow_q;

  // Combinational intermediates.
  logic             accept;
  logic [PTR_W-1:0] rq2;
  logic [PTR_W-1:0] rbin_sync;
  logic [PTR_W-1:0] rgray_full;
  logic [PTR_W-1:0] occupancy;

  // Read-pointer synchronizer (rq1/rq2). rq2 is safe to use in this domain.
  fifo_sync_2ff #(
    .WIDTH (PTR_W)
  ) u_rptr_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (rptr_gray_async),
    .q_sync  (rq2)
  );

  // Accept decision. A write is refused while full. It is also refused
  // during reset, so no RAM write can occur while the pointer is cleared.
  always_comb begin
    accept = wr_req & ~full_q & ~rst;
  end

  // Next-state for pointers and status, all based on the post-write pointer.
  // NOTE: every signal assigned in this block gets a value on every path,
  // which keeps the block free of inferred latches.
  always_comb begin
    wbin_d      = wbin_q + {{ADDR_WIDTH{1'b0}}, accept};
    wptr_gray_d = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_d)));

    // The FIFO is full when the write pointer is one lap ahead of the read pointer.
    // In Gray code that means the top two bits are inverted and the rest are equal.
    rgray_full  = {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]};
    full_d      = (wptr_gray_d == rgray_full);

    // Occupancy uses the late read pointer, so it never under-reports.
    rbin_sync     = PTR_W'(gray2bin(GRAY_MAX_W'(rq2)));
    occupancy     = wbin_d - rbin_sync;
    wr_count_d    = occupancy;
    almost_full_d = (occupancy >= AFULL_TH_P);

    // A refused request sets overflow. If a clear arrives in the same cycle, the set wins.
    overflow_d = overflow_q;
    if (wr_req && full_q) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Pointer and status registers. Reset takes priority over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q        <= '0;
      wptr_gray_q   <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wr_count_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_gray_q   <= wptr_gray_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      wr_count_q    <= wr_count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Output mapping. The Gray pointer sent to the read domain comes straight from a flop.
  assign wr_accept   = accept;
  assign ram_wen     = accept;
  assign ram_waddr   = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray   = wptr_gray_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_count    = wr_count_q;
  assign overflow    = overflow_q;

endmodule
